// File: rtl/mult_ctrl_pkg.sv
// Shared state encoding, operand-half selects and shift codes for the
// 8x8 shift-add multiplier controller.
package mult_ctrl_pkg;

  // Codes are fixed because they feed the seven-segment debug display.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP0 = 3'd1,
    S_STEP1 = 3'd2,
    S_STEP2 = 3'd3,
    S_STEP3 = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  localparam logic [1:0] SH_0 = 2'd0;
  localparam logic [1:0] SH_4 = 2'd1;
  localparam logic [1:0] SH_8 = 2'd2;

endpackage

// File: rtl/mult8x8_ctrl.sv
// Sequencing FSM for the 4x4-based shift-add 8x8 multiplier datapath.
// Define MULT_ERR_EN to abort to ERR (with an err output) on start while busy.
module mult8x8_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       start,
  output logic       sel_a,
  output logic       sel_b,
  output logic [1:0] shift,
  output logic       acc_en,
  output logic       acc_sclr,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_out
`ifdef MULT_ERR_EN
  ,
  output logic       err
`endif
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_STEP0;
      S_STEP0: state_nxt = S_STEP1;
      S_STEP1: state_nxt = S_STEP2;
      S_STEP2: state_nxt = S_STEP3;
      S_STEP3: state_nxt = S_DONE;
      S_DONE: begin
        if (start)           state_nxt = S_STEP0;
        else if (DONE_PULSE) state_nxt = S_IDLE;
      end
`ifdef MULT_ERR_EN
      S_ERR:   if (!start) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
`ifdef MULT_ERR_EN
    if (busy && start) state_nxt = S_ERR;
`endif
  end

  // Moore decode of the state register; only the start-acceptance clear
  // looks at start directly so the accumulator is zeroed on that same edge.
  always_comb begin
    sel_a    = SEL_LO;
    sel_b    = SEL_LO;
    shift    = SH_0;
    acc_en   = 1'b0;
    acc_sclr = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
`ifdef MULT_ERR_EN
    err      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        acc_en   = start;
        acc_sclr = !start;
      end
      S_STEP0: begin
        acc_en = 1'b1;
        busy   = 1'b1;
      end
      S_STEP1: begin
        sel_a  = SEL_HI;
        shift  = SH_4;
        acc_en = 1'b1;
        busy   = 1'b1;
      end
      S_STEP2: begin
        sel_b  = SEL_HI;
        shift  = SH_4;
        acc_en = 1'b1;
        busy   = 1'b1;
      end
      S_STEP3: begin
        sel_a  = SEL_HI;
        sel_b  = SEL_HI;
        shift  = SH_8;
        acc_en = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        acc_en   = start;
        acc_sclr = !start;
      end
`ifdef MULT_ERR_EN
      S_ERR:   err = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_mult8x8_ctrl.sv
// Bench for mult8x8_ctrl: drives two instances (pulsed and held done) into a
// behavioural shift-add datapath and scores accumulator products.
module tb_mult8x8_ctrl;

  logic        clk = 1'b0;
  logic        aclr = 1'b0;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic [7:0]  a_op = 8'h00, b_op = 8'h00, a0_op = 8'h00, b0_op = 8'h00;
  logic [15:0] acc = 16'h0000, acc0 = 16'h0000;

  logic       sel_a, sel_b, acc_en, acc_sclr, busy, done;
  logic [1:0] shift;
  logic [2:0] state_out;
  logic       sel_a0, sel_b0, acc_en0, acc_sclr0, busy0, done0;
  logic [1:0] shift0;
  logic [2:0] state_out0;
`ifdef MULT_ERR_EN
  logic       err, err0;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;
  logic [10:0] ctl;
  logic [10:0] seq_tbl[7];

  localparam logic [10:0] RST_VEC = 11'b0_0_00_0_1_0_0_000;

  always #5 clk = ~clk;

  mult8x8_ctrl #(.DONE_PULSE(1'b1)) dut (
    .clk(clk), .aclr(aclr), .start(start),
    .sel_a(sel_a), .sel_b(sel_b), .shift(shift),
    .acc_en(acc_en), .acc_sclr(acc_sclr), .busy(busy), .done(done),
    .state_out(state_out)
`ifdef MULT_ERR_EN
    , .err(err)
`endif
  );

  mult8x8_ctrl #(.DONE_PULSE(1'b0)) dut0 (
    .clk(clk), .aclr(aclr), .start(start0),
    .sel_a(sel_a0), .sel_b(sel_b0), .shift(shift0),
    .acc_en(acc_en0), .acc_sclr(acc_sclr0), .busy(busy0), .done(done0),
    .state_out(state_out0)
`ifdef MULT_ERR_EN
    , .err(err0)
`endif
  );

  assign ctl = {sel_a, sel_b, shift, acc_en, acc_sclr, busy, done, state_out};

  function automatic logic [15:0] dp_term(input logic [7:0] a, input logic [7:0] b,
                                          input logic sa, input logic sb,
                                          input logic [1:0] sh);
    logic [7:0]  p;
    logic [15:0] r;
    p = {4'h0, (sa ? a[7:4] : a[3:0])} * {4'h0, (sb ? b[7:4] : b[3:0])};
    case (sh)
      2'd0:    r = {8'h00, p};
      2'd1:    r = {4'h0, p, 4'h0};
      default: r = {p, 8'h00};
    endcase
    return r;
  endfunction

  // Behavioural datapath: 4x4 multiply, shift, add, 16-bit accumulator.
  always @(posedge clk) begin
    if (acc_en)  acc  <= acc_sclr  ? acc  + dp_term(a_op, b_op, sel_a, sel_b, shift)      : 16'h0000;
    if (acc_en0) acc0 <= acc_sclr0 ? acc0 + dp_term(a0_op, b0_op, sel_a0, sel_b0, shift0) : 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (aclr && done) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("product", {16'h0, acc}, {16'h0, sb_exp});
      end
    end
  end

  task automatic mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                     input int poke);
    int cyc;
    @(posedge clk); #1;
    a_op = a; b_op = b; start = 1'b1;
    exp_q.push_back(exp);
    cyc = 9;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      start = (i == poke);
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
    check("done_cycle", cyc, 5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seq_tbl[0] = 11'b0_0_00_1_0_0_0_000;
    seq_tbl[1] = 11'b0_0_00_1_1_1_0_001;
    seq_tbl[2] = 11'b1_0_01_1_1_1_0_010;
    seq_tbl[3] = 11'b0_1_01_1_1_1_0_011;
    seq_tbl[4] = 11'b1_1_10_1_1_1_0_100;
    seq_tbl[5] = 11'b0_0_00_0_1_0_1_101;
    seq_tbl[6] = 11'b0_0_00_0_1_0_0_000;

    #12;
    check("rst_ctl", {21'h0, ctl}, {21'h0, RST_VEC});
    aclr = 1'b1;

    // Cycle-by-cycle control sequence, FF x FF
    @(posedge clk); #1;
    a_op = 8'hFF; b_op = 8'hFF; start = 1'b1;
    exp_q.push_back(16'hFE01);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("seq_ctl", {21'h0, ctl}, {21'h0, seq_tbl[c]});
      @(posedge clk); #1;
      start = 1'b0;
    end

    mul(8'h12, 8'h34, 16'h03A8, 0);
    mul(8'h00, 8'hAB, 16'h0000, 0);

    // Back-to-back: new start accepted in DONE
    @(posedge clk); #1;
    a_op = 8'h0F; b_op = 8'hF0; start = 1'b1;
    exp_q.push_back(16'h0E10);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_in_done", state_out, 5);
    a_op = 8'h80; b_op = 8'h02; start = 1'b1;
    exp_q.push_back(16'h0100);
    @(negedge clk);
    check("b2b_clear", {acc_en, acc_sclr}, 2'b10);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_no_idle", state_out, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("b2b_done2", done, 1);

    // Asynchronous reset in the middle of STEP2
    @(posedge clk); #1;
    a_op = 8'h12; b_op = 8'h34; start = 1'b1;
    exp_q.push_back(16'h03A8);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_aclr_state", state_out, 3);
    #2;
    aclr = 1'b0;
    #1;
    check("aclr_ctl", {21'h0, ctl}, {21'h0, RST_VEC});
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    aclr = 1'b1;
    check("aclr_held_idle", state_out, 0);
    mul(8'hFF, 8'hFF, 16'hFE01, 0);

    // start pulsed during STEP1
`ifdef MULT_ERR_EN
    @(posedge clk); #1;
    a_op = 8'h12; b_op = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    check("err_step1", state_out, 2);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_state", state_out, 6);
    check("err_flag", err, 1);
    check("err_quiet", {busy, done, acc_en}, 3'b000);
    @(posedge clk); #1;
    check("err_hold", state_out, 6);
    start = 1'b0;
    @(posedge clk); #1;
    check("err_exit", state_out, 0);
    check("err_clear", err, 0);
`else
    mul(8'h12, 8'h34, 16'h03A8, 2);
`endif
    mul(8'h0F, 8'hF0, 16'h0E10, 0);

    // Held-done instance: done persists, accumulator frozen
    @(posedge clk); #1;
    a0_op = 8'h12; b0_op = 8'h34; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check("hold_done", done0, 1);
      check("hold_acc", {16'h0, acc0}, 32'h03A8);
      check("hold_en", acc_en0, 0);
      @(posedge clk);
    end
    #1;
    a0_op = 8'h80; b0_op = 8'h02; start0 = 1'b1;
    @(negedge clk);
    check("hold_restart_clr", {acc_en0, acc_sclr0}, 2'b10);
    @(posedge clk); #1;
    start0 = 1'b0;
    check("hold_restart_step0", state_out0, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("hold_done2", done0, 1);
    check("hold_acc2", {16'h0, acc0}, 32'h0100);

    repeat (2) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
